// File: rtl/muldiv_sched.sv
// muldiv_sched: sequencer for the shared multiply/divide unit that owns HI/LO writes.
// Multiply is a registered 64-bit product with MUL_LAT cycles of occupancy; divide is
// restoring radix-2 producing one quotient bit per cycle, MSB first.
// Optional feature macro: MULDIV_EARLY_EXIT_EN. When defined, a divide whose divisor is zero
// or whose divisor magnitude exceeds the dividend magnitude goes straight to DONE.
//
// state | meaning
// IDLE  | waiting for a request from execute
// MUL   | multiply occupancy countdown
// DIV   | one restoring-divide iteration per cycle
// DONE  | result valid, single HI/LO write strobe
module muldiv_sched #(
   parameter int MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [1:0]  req_op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic        stall_req,
   output logic        hilo_we,
   output logic [31:0] hilo_hi,
   output logic [31:0] hilo_lo,
   output logic        busy
);

   localparam int CW = 8;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [31:0]    a_q, a_d;
   logic [31:0]    b_q, b_d;
   logic           sgn_q, sgn_d;
   logic [31:0]    rem_q, rem_d;
   logic [31:0]    quo_q, quo_d;
   logic [63:0]    res_q, res_d;

   logic           op_div, op_sgn;
   logic [31:0]    a_mag_in;
   logic [31:0]    b_mag;
   logic [32:0]    rem_sh;
   logic           q_bit;
   logic [31:0]    rem_nx, quo_nx, rem_fix, quo_fix;
   logic [63:0]    a_ext, b_ext, prod;
   logic           stall_c, we_c;

   assign op_div   = req_op[1];
   assign op_sgn   = ~req_op[0];
   assign a_mag_in = (op_sgn & src_a[31]) ? (~src_a + 32'd1) : src_a;

`ifdef MULDIV_EARLY_EXIT_EN
   logic [31:0]    b_mag_in;
   logic           early_c;
   assign b_mag_in = (op_sgn & src_b[31]) ? (~src_b + 32'd1) : src_b;
   assign early_c  = (src_b == 32'd0) | (b_mag_in > a_mag_in);
`endif

   // Divider datapath: shift in the next dividend bit, subtract if it fits.
   assign b_mag   = (sgn_q & b_q[31]) ? (~b_q + 32'd1) : b_q;
   assign rem_sh  = {rem_q, quo_q[31]};
   assign q_bit   = (rem_sh >= {1'b0, b_mag});
   assign rem_nx  = q_bit ? 32'(rem_sh - {1'b0, b_mag}) : rem_sh[31:0];
   assign quo_nx  = {quo_q[30:0], q_bit};
   assign quo_fix = (sgn_q & (a_q[31] ^ b_q[31])) ? (~quo_nx + 32'd1) : quo_nx;
   assign rem_fix = (sgn_q & a_q[31]) ? (~rem_nx + 32'd1) : rem_nx;

   // Sign-extending to 64 bits keeps the low 64 product bits right for both signednesses.
   assign a_ext = {{32{sgn_q & a_q[31]}}, a_q};
   assign b_ext = {{32{sgn_q & b_q[31]}}, b_q};
   assign prod  = a_ext * b_ext;

   // Next-state, datapath update and strobe generation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      sgn_d   = sgn_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      res_d   = res_q;
      stall_c = 1'b0;
      we_c    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid && !flush) begin
               stall_c = 1'b1;
               a_d     = src_a;
               b_d     = src_b;
               sgn_d   = op_sgn;
               if (op_div) begin
                  state_d = S_DIV;
                  cnt_d   = CW'(31);
                  rem_d   = 32'd0;
                  quo_d   = a_mag_in;
`ifdef MULDIV_EARLY_EXIT_EN
                  if (early_c) begin
                     state_d = S_DONE;
                     cnt_d   = '0;
                     res_d   = (src_b == 32'd0) ? {src_a, 32'hFFFF_FFFF} : {src_a, 32'h0};
                  end
`endif
               end else begin
                  state_d = S_MUL;
                  cnt_d   = CW'(MUL_LAT - 1);
               end
            end
         end
         S_MUL: begin
            stall_c = 1'b1;
            if (flush) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = S_DONE;
               res_d   = prod;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DIV: begin
            stall_c = 1'b1;
            if (flush) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               rem_d = rem_nx;
               quo_d = quo_nx;
               if (cnt_q == '0) begin
                  state_d = S_DONE;
                  res_d   = (b_q == 32'd0) ? {a_q, 32'hFFFF_FFFF} : {rem_fix, quo_fix};
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
         end
         S_DONE: begin
            we_c    = ~flush;
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         rem_q   <= '0;
         quo_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgn_q   <= sgn_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         res_q   <= res_d;
      end
   end

   // Strobes are gated by reset so they drop the instant reset asserts.
   assign stall_req = stall_c & ~reset;
   assign hilo_we   = we_c & ~reset;
   assign hilo_hi   = res_q[63:32];
   assign hilo_lo   = res_q[31:0];
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_muldiv_sched.sv
// Bench for muldiv_sched: reference results from plain integer arithmetic, per-cycle
// expectations from an occupancy countdown, plus literal checks on known operations.
module tb_muldiv_sched;
   localparam int MUL_LAT = 2;

   logic        clk = 1'b0;
   logic        reset, req_valid, flush;
   logic [1:0]  req_op;
   logic [31:0] src_a, src_b;
   logic        stall_req, hilo_we, busy;
   logic [31:0] hilo_hi, hilo_lo;

   muldiv_sched #(.MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
      .src_a(src_a), .src_b(src_b), .flush(flush), .stall_req(stall_req),
      .hilo_we(hilo_we), .hilo_hi(hilo_hi), .hilo_lo(hilo_lo), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   bit          m_busy = 1'b0;
   int          m_left = 0;
   logic [63:0] m_res = '0;
   int          we_count = 0, last_we_cyc = 0, acc_cyc = 0;
   logic [31:0] last_hi = '0, last_lo = '0;
   logic        s_stall, s_we, s_busy;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         if (n_bad <= 40)
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      res = '0;
      case (op)
         2'b00: res = 64'(sa * sb);
         2'b01: res = {32'b0, a} * {32'b0, b};
         2'b10: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               res = {32'(r), 32'(q)};
            end
         end
         default: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else res = {a % b, a / b};
         end
      endcase
      return res;
   endfunction

   // Cycles from the accept cycle to the DONE cycle.
   function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_EXIT_EN
      longint ma, mb;
`endif
      if (!op[1]) return MUL_LAT + 1;
`ifdef MULDIV_EARLY_EXIT_EN
      ma = op[0] ? longint'({32'b0, a}) : longint'($signed(a));
      mb = op[0] ? longint'({32'b0, b}) : longint'($signed(b));
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
      if (b == 0 || mb > ma) return 1;
`endif
      return 33;
   endfunction

   // One clock cycle: drive, compare at negedge against the model, advance the model.
   task automatic step(input bit rv, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit fl, input bit rst);
      logic e_stall, e_we, e_busy;
      req_valid = rv; req_op = op; src_a = a; src_b = b; flush = fl; reset = rst;
      @(negedge clk);
      s_stall = stall_req; s_we = hilo_we; s_busy = busy;
      if (rst) begin
         e_stall = 1'b0; e_we = 1'b0; e_busy = 1'b0;
      end else if (!m_busy) begin
         e_stall = rv & ~fl; e_we = 1'b0; e_busy = 1'b0;
      end else if (m_left > 0) begin
         e_stall = 1'b1; e_we = 1'b0; e_busy = 1'b1;
      end else begin
         e_stall = 1'b0; e_we = ~fl; e_busy = 1'b1;
      end
      chk("stall_req", 64'(stall_req), 64'(e_stall));
      chk("hilo_we", 64'(hilo_we), 64'(e_we));
      chk("busy", 64'(busy), 64'(e_busy));
      if (rst) chk("hilo_reset", {hilo_hi, hilo_lo}, 64'h0);
      if (e_we && hilo_we) chk("hilo_value", {hilo_hi, hilo_lo}, m_res);
      if (hilo_we) begin
         we_count++;
         last_we_cyc = cyc;
         last_hi = hilo_hi;
         last_lo = hilo_lo;
      end
      if (rst) m_busy = 1'b0;
      else if (!m_busy) begin
         if (rv && !fl) begin
            m_busy = 1'b1;
            m_left = ref_lat(op, a, b) - 1;
            m_res  = ref_result(op, a, b);
            acc_cyc = cyc;
         end
      end else if (m_left == 0 || fl) m_busy = 1'b0;
      else m_left--;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Request held high until the write strobe, then two idle cycles.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int nwe);
      int w0, n;
      w0 = we_count;
      n = 0;
      step(1'b1, op, a, b, 1'b0, 1'b0);
      while (!s_we && n < 80) begin
         step(1'b1, op, a, b, 1'b0, 1'b0);
         n++;
      end
      chk("op_timeout", 64'(n < 80), 64'd1);
      step(1'b0, op, a, b, 1'b0, 1'b0);
      step(1'b0, op, a, b, 1'b0, 1'b0);
      lat = last_we_cyc - acc_cyc;
      nwe = we_count - w0;
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 20));
         5: return 32'h0 - 32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   localparam int EE_LAT =
`ifdef MULDIV_EARLY_EXIT_EN
      1;
`else
      33;
`endif

   initial begin
      int lat, nwe, w0;
      step(1'b1, 2'b00, 32'd3, 32'd4, 1'b0, 1'b1);
      chk("reset_stall", 64'(s_stall), 64'd0);
      step(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1);
      step(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);

      run_op(2'b00, 32'hFFFF_FFFD, 32'd7, lat, nwe);
      chk("t1_lat", 64'(lat), 64'd3);
      chk("t1_nwe", 64'(nwe), 64'd1);
      chk("t1_hi", 64'(last_hi), 64'hFFFF_FFFF);
      chk("t1_lo", 64'(last_lo), 64'hFFFF_FFEB);

      run_op(2'b01, 32'hFFFF_FFFF, 32'd2, lat, nwe);
      chk("t2_nwe", 64'(nwe), 64'd1);
      chk("t2_hi", 64'(last_hi), 64'h1);
      chk("t2_lo", 64'(last_lo), 64'hFFFF_FFFE);

      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, nwe);
      chk("t3_lat", 64'(lat), 64'd33);
      chk("t3_lo", 64'(last_lo), 64'hFFFF_FFFD);
      chk("t3_hi", 64'(last_hi), 64'hFFFF_FFFF);
      run_op(2'b11, 32'd7, 32'd2, lat, nwe);
      chk("t3u_lo", 64'(last_lo), 64'd3);
      chk("t3u_hi", 64'(last_hi), 64'd1);

      run_op(2'b11, 32'd5, 32'd0, lat, nwe);
      chk("t4_lat", 64'(lat), 64'(EE_LAT));
      chk("t4_lo", 64'(last_lo), 64'hFFFF_FFFF);
      chk("t4_hi", 64'(last_hi), 64'd5);
      run_op(2'b11, 32'd3, 32'd9, lat, nwe);
      chk("t4e_lat", 64'(lat), 64'(EE_LAT));
      chk("t4e_lo", 64'(last_lo), 64'd0);
      chk("t4e_hi", 64'(last_hi), 64'd3);

      // Flush ten cycles into a divide, then a multiply right behind it.
      w0 = we_count;
      step(1'b1, 2'b10, 32'd100, 32'd7, 1'b0, 1'b0);
      for (int i = 1; i <= 9; i++) step(1'b1, 2'b10, 32'd100, 32'd7, 1'b0, 1'b0);
      step(1'b1, 2'b10, 32'd100, 32'd7, 1'b1, 1'b0);
      run_op(2'b00, 32'd6, 32'd7, lat, nwe);
      chk("t5_mul_lat", 64'(lat), 64'd3);
      chk("t5_mul_lo", 64'(last_lo), 64'd42);
      for (int i = 0; i < 40; i++) step(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
      chk("t5_writes", 64'(we_count - w0), 64'd1);

      // Reset during a multiply.
      w0 = we_count;
      step(1'b1, 2'b00, 32'd3, 32'd5, 1'b0, 1'b0);
      step(1'b1, 2'b00, 32'd3, 32'd5, 1'b0, 1'b1);
      chk("t6_busy", 64'(s_busy), 64'd0);
      chk("t6_stall", 64'(s_stall), 64'd0);
      step(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
      chk("t6_writes", 64'(we_count - w0), 64'd0);
      run_op(2'b01, 32'd9, 32'd9, lat, nwe);
      chk("t6_nwe", 64'(nwe), 64'd1);
      chk("t6_lo", 64'(last_lo), 64'd81);

      for (int i = 0; i < 5000; i++) begin
         step($urandom_range(0, 9) < 7, 2'($urandom), rand_operand(), rand_operand(),
              $urandom_range(0, 39) == 0, $urandom_range(0, 599) == 0);
      end
      step(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
